mem_ctrl: RTL
=============

# mem_ctrl

Memory controller: responder for the fetcher's instruction-query pulse protocol and for the load/store buffer's data requests. Sits between the core and the byte-wide unified RAM/IO bus. Serializes each request into 1–4 byte bus cycles and assembles or disassembles little-endian words. Returns a one-cycle finish pulse to the requester.

## Interface
- No parameters.
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- rdy  in  1  global enable; low freezes all state
- start_query_signal  in  1  fetch request pulse
- query_pc  in  32  fetch address, valid with the pulse
- finish_query_signal  out  1  fetch done pulse; reset 0
- queried_inst  out  32  fetched word, valid with finish; reset 0
- misbranch_flag  in  1  ROB flush
- lsb_start  in  1  data request pulse
- lsb_wr  in  1  1 = store, 0 = load
- lsb_addr  in  32  byte address
- lsb_len  in  3  byte count: 1, 2 or 4
- lsb_wdata  in  32  store data; low lsb_len bytes used
- lsb_finish  out  1  data done pulse; reset 0
- lsb_rdata  out  32  load data, zero-extended; reset 0
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte; reset 0
- mem_a  out  32  RAM address; reset 0
- mem_wr  out  1  1 = write; reset 0
- io_buffer_full  in  1  UART TX buffer full

## Operation
- **States:** IDLE, IFETCH, LOAD, STORE. Byte counter `cnt` runs 0..4. Assembly register is 32 bits.
- **Request capture:**
  - Both start pulses latch into pending flags along with their address, length and data.
  - Latching happens on any edge, including edges where rdy is low.
  - A flag clears when its request is accepted.
- **Arbitration (IDLE only):** pending LSB wins over pending fetch. A fetch is 4 bytes at query_pc.
- **Read (IFETCH/LOAD):**
  - On accept edge E0: mem_a <= addr, mem_wr <= 0.
  - On Ek (k ≥ 1): mem_a <= addr+k while k < N.
  - Byte k is sampled from mem_din at E(k+1); byte k goes to bits [8k+7:8k].
  - At E(N): the result is written with the final byte merged in directly from mem_din; the finish pulse goes high and the state returns to IDLE.
- **Write (STORE):**
  - On Ek for k = 0..N-1: mem_a <= addr+k, mem_dout <= byte k, mem_wr <= 1.
  - At EN: mem_wr <= 0, mem_a <= 0, lsb_finish pulses, state returns to IDLE.
- **Pulses:** finish outputs are high for exactly one cycle and default to 0 on every other edge. Data outputs hold until the next finish.
- **Misbranch:**
  - misbranch_flag high clears the pending fetch.
  - If in IFETCH, the fetch is aborted: state goes to IDLE, mem_a <= 0, and no finish pulse is issued.
  - A fetch start pulse on the same edge as misbranch is accepted (the new PC).
  - LOAD and STORE are never aborted.
- **Wrap-around:** addr+k is a 32-bit add and wraps modulo 2^32.
- **Illegal length:** an lsb_len other than 1, 2 or 4 is treated as 4.

## Timing
- Read latency: accept edge to finish visible = N+1 cycles (fetch = 5).
- Write latency: N+1 cycles.
- Back-to-back: the next request can be accepted on the edge after finish, so there is one IDLE cycle between transactions.
- **Simultaneous pulses in IDLE:** LSB is served first. The fetch stays pending and starts right after LSB finishes.
- **rdy low:** every register holds, including mem_wr. When rdy rises the transaction resumes exactly where it stopped.
- **Reset:** asynchronous. Asserting it mid-transaction returns to IDLE, clears pending flags, forces all outputs to their reset values, and no finish pulse is issued.

## Configuration
- **MEMCTRL_IO_STALL_EN defined:** a STORE whose address satisfies addr[17:16] == 2'b11 holds before each byte while io_buffer_full is high. During the hold: mem_wr = 0, cnt is frozen, and the byte is issued once the buffer is no longer full.
- **Not defined:** io_buffer_full is ignored.

## Structure
- Add to the shared constants file:
  - MEM_LEN_TYPE width
  - MEMCTRL_STATE_TYPE and its four encodings
  - IO_ADDR_BITS constant (17:16)
  - reuse ADDR_TYPE and INST_TYPE
- One sub-module, `mem_req_latch`: pulse-to-pending capture with stored payload and a clear input. Instantiated once for fetch and once for LSB.

## Test plan
- **Fetch:** RAM 0x0000_0010..13 = 13 05 00 00; pulse query_pc = 0x10. Expect mem_a = 0x10..0x13, then finish_query_signal pulses 5 cycles after accept with queried_inst = 0x00000513.
- **Load half:** lsb_addr = 0x200, len = 2, RAM = EF BE. Expect lsb_finish after 3 cycles and lsb_rdata = 0x0000BEEF.
- **Store word:** addr = 0x100, wdata = 0xDEADBEEF. Expect mem_wr high for 4 cycles with bytes EF BE AD DE, lsb_finish on cycle 5, then RAM read-back matches.
- **Simultaneous pulses:** fetch at 0x0 and load at 0x40 in the same cycle. Load completes first, then the fetch starts on the next IDLE edge; two finish pulses, no data mix.
- **Misbranch:** misbranch_flag asserted in the 2nd IFETCH cycle. Expect no finish_query_signal and mem_a = 0 next cycle. A new query pulse at 0x80 completes normally.
- **IO stall (macro on):** store 1 byte to 0x30000 with io_buffer_full held high for 3 cycles. Expect mem_wr to stay 0 for 3 cycles, then one write, then lsb_finish.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the memory controller: address/instruction types,
// request length type, controller state encoding and the IO address tag.
package mem_ctrl_pkg;

   typedef logic [31:0] ADDR_TYPE;
   typedef logic [31:0] INST_TYPE;

   localparam int MEM_LEN_W = 3;
   typedef logic [MEM_LEN_W-1:0] MEM_LEN_TYPE;

   typedef enum logic [1:0] {
      MC_IDLE   = 2'd0,
      MC_IFETCH = 2'd1,
      MC_LOAD   = 2'd2,
      MC_STORE  = 2'd3
   } MEMCTRL_STATE_TYPE;

   // Address bits that select the memory-mapped IO window
   localparam int         IO_ADDR_HI  = 17;
   localparam int         IO_ADDR_LO  = 16;
   localparam logic [1:0] IO_ADDR_TAG = 2'b11;

   // Byte counts other than 1, 2 or 4 are served as a full word
   function automatic MEM_LEN_TYPE norm_len(input MEM_LEN_TYPE len);
      case (len)
         3'd1:    return 3'd1;
         3'd2:    return 3'd2;
         3'd4:    return 3'd4;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl_req_latch.sv
// mem_req_latch: turns a one-cycle request pulse into a pending flag with a
// stored payload. Capture is independent of the global enable so no pulse is
// lost while the core is stalled. A pulse on the same edge as a clear wins.
module mem_req_latch #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         start_i,
   input  logic         clr_i,
   input  logic [W-1:0] data_i,
   output logic         pend_o,
   output logic [W-1:0] data_o
);

   logic         pend_q;
   logic [W-1:0] data_q;

   // Capture a new request, otherwise drop the pending flag when cleared
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend_q <= 1'b0;
         data_q <= {W{1'b0}};
      end else if (start_i) begin
         pend_q <= 1'b1;
         data_q <= data_i;
      end else if (clr_i) begin
         pend_q <= 1'b0;
      end
   end

   assign pend_o = pend_q;
   assign data_o = data_q;

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: serves instruction fetches and load/store-buffer requests over a
// byte-wide RAM/IO bus, one byte per cycle, little-endian assembly.
// Optional build macro MEMCTRL_IO_STALL_EN: stores into the IO window
// (addr[17:16] == 2'b11) wait before each byte while io_buffer_full is high.
module mem_ctrl
   import mem_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        start_query_signal,
   input  logic [31:0] query_pc,
   output logic        finish_query_signal,
   output logic [31:0] queried_inst,
   input  logic        misbranch_flag,
   input  logic        lsb_start,
   input  logic        lsb_wr,
   input  logic [31:0] lsb_addr,
   input  logic [2:0]  lsb_len,
   input  logic [31:0] lsb_wdata,
   output logic        lsb_finish,
   output logic [31:0] lsb_rdata,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full
);

   localparam int LSB_PAY_W = 1 + 32 + MEM_LEN_W + 32;

   MEMCTRL_STATE_TYPE state_q;
   logic [2:0]        cnt_q;
   ADDR_TYPE          addr_q;
   MEM_LEN_TYPE       len_q;
   logic [31:0]       wdata_q;
   INST_TYPE          asm_q;

   logic                 fetch_pend_s;
   ADDR_TYPE             fetch_pc_s;
   logic                 fetch_clr_s;
   logic                 lsb_pend_s;
   logic [LSB_PAY_W-1:0] lsb_pay_s;
   logic                 lsb_p_wr_s;
   ADDR_TYPE             lsb_p_addr_s;
   MEM_LEN_TYPE          lsb_p_len_s;
   logic [31:0]          lsb_p_wdata_s;

   logic       accept_lsb_s;
   logic       accept_fetch_s;
   ADDR_TYPE   cnt_addr_s;
   logic [1:0] byte_sel_s;
   INST_TYPE   merged_s;
   logic [7:0] store_byte_s;
   logic       io_stall_acc_s;
   logic       io_stall_run_s;

   mem_req_latch #(.W(32)) u_fetch_req (
      .clk_i   (clk),
      .rst_ni  (rst),
      .start_i (start_query_signal),
      .clr_i   (fetch_clr_s),
      .data_i  (query_pc),
      .pend_o  (fetch_pend_s),
      .data_o  (fetch_pc_s)
   );

   mem_req_latch #(.W(LSB_PAY_W)) u_lsb_req (
      .clk_i   (clk),
      .rst_ni  (rst),
      .start_i (lsb_start),
      .clr_i   (accept_lsb_s),
      .data_i  ({lsb_wr, lsb_addr, lsb_len, lsb_wdata}),
      .pend_o  (lsb_pend_s),
      .data_o  (lsb_pay_s)
   );

   assign {lsb_p_wr_s, lsb_p_addr_s, lsb_p_len_s, lsb_p_wdata_s} = lsb_pay_s;

   // LSB has priority; a fetch is never started on a flush edge
   assign accept_lsb_s   = rdy & (state_q == MC_IDLE) & lsb_pend_s;
   assign accept_fetch_s = rdy & (state_q == MC_IDLE) & ~lsb_pend_s
                           & fetch_pend_s & ~misbranch_flag;
   assign fetch_clr_s    = accept_fetch_s | misbranch_flag;

`ifdef MEMCTRL_IO_STALL_EN
   assign io_stall_acc_s = io_buffer_full
                           & (lsb_p_addr_s[IO_ADDR_HI:IO_ADDR_LO] == IO_ADDR_TAG);
   assign io_stall_run_s = io_buffer_full
                           & (addr_q[IO_ADDR_HI:IO_ADDR_LO] == IO_ADDR_TAG);
`else
   // Buffer status has no effect in this build
   assign io_stall_acc_s = io_buffer_full & 1'b0;
   assign io_stall_run_s = io_buffer_full & 1'b0;
`endif

   // Byte address, read-byte merge position and next store byte
   always_comb begin
      cnt_addr_s   = addr_q + {29'd0, cnt_q};
      byte_sel_s   = cnt_q[1:0] - 2'd1;
      merged_s     = asm_q;
      merged_s[{byte_sel_s, 3'b000} +: 8] = mem_din;
      store_byte_s = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
   end

   // Sequencer: arbitration, byte-serial bus cycles and finish pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q             <= MC_IDLE;
         cnt_q               <= 3'd0;
         addr_q              <= 32'd0;
         len_q               <= 3'd0;
         wdata_q             <= 32'd0;
         asm_q               <= 32'd0;
         finish_query_signal <= 1'b0;
         queried_inst        <= 32'd0;
         lsb_finish          <= 1'b0;
         lsb_rdata           <= 32'd0;
         mem_dout            <= 8'd0;
         mem_a               <= 32'd0;
         mem_wr              <= 1'b0;
      end else if (rdy) begin
         finish_query_signal <= 1'b0;
         lsb_finish          <= 1'b0;
         case (state_q)
            MC_IDLE: begin
               if (accept_lsb_s) begin
                  addr_q  <= lsb_p_addr_s;
                  len_q   <= norm_len(lsb_p_len_s);
                  wdata_q <= lsb_p_wdata_s;
                  asm_q   <= 32'd0;
                  mem_a   <= lsb_p_addr_s;
                  if (lsb_p_wr_s) begin
                     state_q <= MC_STORE;
                     if (io_stall_acc_s) begin
                        mem_wr <= 1'b0;
                        cnt_q  <= 3'd0;
                     end else begin
                        mem_dout <= lsb_p_wdata_s[7:0];
                        mem_wr   <= 1'b1;
                        cnt_q    <= 3'd1;
                     end
                  end else begin
                     state_q <= MC_LOAD;
                     mem_wr  <= 1'b0;
                     cnt_q   <= 3'd1;
                  end
               end else if (accept_fetch_s) begin
                  state_q <= MC_IFETCH;
                  addr_q  <= fetch_pc_s;
                  len_q   <= 3'd4;
                  asm_q   <= 32'd0;
                  mem_a   <= fetch_pc_s;
                  mem_wr  <= 1'b0;
                  cnt_q   <= 3'd1;
               end else begin
                  mem_wr <= 1'b0;
               end
            end
            MC_IFETCH, MC_LOAD: begin
               if ((state_q == MC_IFETCH) && misbranch_flag) begin
                  state_q <= MC_IDLE;
                  cnt_q   <= 3'd0;
                  mem_a   <= 32'd0;
               end else if (cnt_q < len_q) begin
                  asm_q <= merged_s;
                  mem_a <= cnt_addr_s;
                  cnt_q <= cnt_q + 3'd1;
               end else begin
                  if (state_q == MC_IFETCH) begin
                     queried_inst        <= merged_s;
                     finish_query_signal <= 1'b1;
                  end else begin
                     lsb_rdata  <= merged_s;
                     lsb_finish <= 1'b1;
                  end
                  state_q <= MC_IDLE;
                  cnt_q   <= 3'd0;
               end
            end
            MC_STORE: begin
               if (cnt_q < len_q) begin
                  if (io_stall_run_s) begin
                     mem_wr <= 1'b0;
                  end else begin
                     mem_a    <= cnt_addr_s;
                     mem_dout <= store_byte_s;
                     mem_wr   <= 1'b1;
                     cnt_q    <= cnt_q + 3'd1;
                  end
               end else begin
                  mem_wr     <= 1'b0;
                  mem_a      <= 32'd0;
                  lsb_finish <= 1'b1;
                  state_q    <= MC_IDLE;
                  cnt_q      <= 3'd0;
               end
            end
            default: begin
               state_q <= MC_IDLE;
               cnt_q   <= 3'd0;
               mem_wr  <= 1'b0;
            end
         endcase
      end
   end

endmodule
